pin_physics: RTL
================

PIN_PHYSICS -- requirements
Module: pin_physics

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of rack rows; NUM_PINS = ROWS*(ROWS+1)/2.
REQ-002 SHALL have parameter VEL_W, default 16, signed velocity width in px/frame.
REQ-003 SHALL have parameter X_W, default 11, and Y_W, default 10, unsigned position widths.
REQ-004 SHALL have parameters SCREEN_WIDTH, default 1024, SCREEN_HEIGHT, default 768, and FRICTION, default 1, the per-frame speed decrement.
REQ-005 SHALL have parameters SPACING_X, default 96, SPACING_Y, default 60, X0, default 0, and Y0, default 0, the rack geometry.
REQ-006 Port: clk_in  input  1  clock.
REQ-007 Port: rst_in  input  1  synchronous active-high reset.
REQ-008 Port: valid_in  input  1  frame request; it is accepted when ready_out=1.
REQ-009 Port: pins_hit_in  input  NUM_PINS  per-pin impulse flags.
REQ-010 Port: pins_vx_in / pins_vy_in  input  NUM_PINS x VEL_W signed  impulse velocities.
REQ-011 Port: ready_out  output  1  high in IDLE.
REQ-012 Port: done_out  output  1  one-cycle frame-complete pulse.
REQ-013 Port: pins_x  output  NUM_PINS x X_W; pins_y  output  NUM_PINS x Y_W; these are positions.
REQ-014 Port: pins_vx_out / pins_vy_out  output  NUM_PINS x VEL_W signed  current velocities.
REQ-015 Port: pins_moving_out / pins_gone_out  output  NUM_PINS each  per-pin status flags.

Function
REQ-016 The FSM SHALL have states IDLE, UPDATE, DONE: IDLE goes to UPDATE on valid_in; UPDATE goes to DONE after index NUM_PINS-1; DONE goes to IDLE unconditionally.
REQ-017 On acceptance in cycle T, the block SHALL latch pins_hit_in and the velocity inputs, and pin i SHALL update in cycle T+1+i.
REQ-018 done_out SHALL be 1 in cycle T+1+NUM_PINS, and ready_out SHALL return to 1 in cycle T+2+NUM_PINS.
REQ-019 valid_in while ready_out=0 SHALL be ignored, with no queuing.
REQ-020 A pin with a latched hit that is not gone SHALL load the input velocity and set its moving flag; a hit on an already-moving pin SHALL replace its velocity.
REQ-021 A moving pin without a hit SHALL use its stored velocity.
REQ-022 Moving-pin update: x' = x + vx and y' = y + vy SHALL be computed sign-extended to max(X_W,Y_W,VEL_W)+1 bits.
REQ-023 If x'<0, x'>=SCREEN_WIDTH, y'<0 or y'>=SCREEN_HEIGHT, the pin SHALL set gone, clear moving, zero its velocity and hold its last in-range position.
REQ-024 Gone pins SHALL ignore hits until reset.
REQ-025 Friction, applied after the move to each axis independently, SHALL give |v'|=|v|-FRICTION, set v'=0 if |v|<=FRICTION, and never flip the sign.
REQ-026 A moving pin whose vx' and vy' are both 0 SHALL clear moving, and a later hit SHALL restart it.
REQ-027 Pins that are neither hit nor moving SHALL hold all state.
REQ-028 Outputs SHALL be registered and SHALL change per pin during UPDATE; they are coherent only at done_out.

Reset
REQ-029 While rst_in=1 (any state, including mid-frame), the FSM SHALL go to IDLE; ready_out=1 and done_out=0 during reset.
REQ-030 Reset SHALL zero all velocities, clear moving and gone, and restore the rack.
REQ-031 Rack position for row r, slot j (row r holds ROWS-r pins, index row-major) SHALL be x = X0 + r*SPACING_X/2 + j*SPACING_X and y = Y0 + r*SPACING_Y.

Configuration
REQ-032 With PIN_PHYSICS_FRICTION_EN defined, REQ-025 and REQ-026 zero-stop SHALL apply.
REQ-033 Without PIN_PHYSICS_FRICTION_EN, velocities SHALL stay constant until a new hit or gone, and FRICTION SHALL be unused.

Structure
REQ-034 Package pin_physics_pkg SHALL hold the FSM state enum, the rack-position functions (row/slot from index) and the default geometry constants.
REQ-035 Sub-module pin_step SHALL be the combinational single-pin next-state logic (move, bounds, friction), instanced once and muxed by index.

Verification
REQ-036 Reset with defaults -> pin 4 at (48,60), pin 9 at (144,180), ready_out=1.
REQ-037 Hit pin 0 with vx=5, vy=3, FRICTION_EN -> after frame 1 pin 0 at (5,3) with v=(4,2); done_out at T+11; ready_out=1 at T+12.
REQ-038 Pin 3 hit with vx=800 -> x'=1088 >= 1024 -> gone=1, x held 288, v=0; a later hit on pin 3 is ignored.
REQ-039 Pin 0 hit with vx=-1 -> gone=1; pin 1 hit with vx=1, vy=0 -> after frame 1 v=0 and moving=0.
REQ-040 valid_in held high during UPDATE -> exactly one frame per acceptance; rst_in asserted mid-frame -> rack restored next cycle and ready_out=1.
REQ-041 ROWS=5 -> 15 pins; pin 14 at (192,240); done_out at T+16.

Source files
------------

// File: rtl/pin_physics_pkg.sv
// rtl/pin_physics_pkg.sv - pin physics FSM states, default geometry and rack-position helpers
package pin_physics_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int DEF_ROWS          = 4;
    localparam int DEF_VEL_W         = 16;
    localparam int DEF_X_W           = 11;
    localparam int DEF_Y_W           = 10;
    localparam int DEF_SCREEN_WIDTH  = 1024;
    localparam int DEF_SCREEN_HEIGHT = 768;
    localparam int DEF_FRICTION      = 1;
    localparam int DEF_SPACING_X     = 96;
    localparam int DEF_SPACING_Y     = 60;

    function automatic int num_pins(input int rows);
        return rows * (rows + 1) / 2;
    endfunction

    // Row r holds rows-r pins, so row starts are a falling triangular sum.
    function automatic int row_start(input int r, input int rows);
        return r * rows - (r * (r - 1)) / 2;
    endfunction

    function automatic int row_of(input int idx, input int rows);
        int found;
        found = 0;
        for (int r = 0; r < rows; r++) begin
            if (idx >= row_start(r, rows)) found = r;
        end
        return found;
    endfunction

    function automatic int slot_of(input int idx, input int rows);
        return idx - row_start(row_of(idx, rows), rows);
    endfunction

    function automatic int rack_x(input int idx, input int rows, input int x0, input int sx);
        return x0 + (row_of(idx, rows) * sx) / 2 + slot_of(idx, rows) * sx;
    endfunction

    function automatic int rack_y(input int idx, input int rows, input int y0, input int sy);
        return y0 + row_of(idx, rows) * sy;
    endfunction

endpackage

// File: rtl/pin_physics_if.sv
// rtl/pin_physics_if.sv - frame request / pin state bus between pin_physics and its user
interface pin_physics_if #(
    parameter int NUM_PINS = 10,
    parameter int VEL_W    = 16,
    parameter int X_W      = 11,
    parameter int Y_W      = 10
);
    logic                    valid_in;
    logic                    ready_out;
    logic                    done_out;
    logic [NUM_PINS-1:0]     pins_hit_in;
    logic signed [VEL_W-1:0] pins_vx_in  [NUM_PINS];
    logic signed [VEL_W-1:0] pins_vy_in  [NUM_PINS];
    logic [X_W-1:0]          pins_x      [NUM_PINS];
    logic [Y_W-1:0]          pins_y      [NUM_PINS];
    logic signed [VEL_W-1:0] pins_vx_out [NUM_PINS];
    logic signed [VEL_W-1:0] pins_vy_out [NUM_PINS];
    logic [NUM_PINS-1:0]     pins_moving_out;
    logic [NUM_PINS-1:0]     pins_gone_out;

    modport master (
        output valid_in, pins_hit_in, pins_vx_in, pins_vy_in,
        input  ready_out, done_out, pins_x, pins_y, pins_vx_out, pins_vy_out,
               pins_moving_out, pins_gone_out
    );

    modport slave (
        input  valid_in, pins_hit_in, pins_vx_in, pins_vy_in,
        output ready_out, done_out, pins_x, pins_y, pins_vx_out, pins_vy_out,
               pins_moving_out, pins_gone_out
    );
endinterface

// File: rtl/pin_physics_pin_step.sv
// rtl/pin_physics_pin_step.sv - combinational next state of one pin (PIN_PHYSICS_FRICTION_EN enables friction)
module pin_step
    import pin_physics_pkg::*;
#(
    parameter int VEL_W         = DEF_VEL_W,
    parameter int X_W           = DEF_X_W,
    parameter int Y_W           = DEF_Y_W,
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int FRICTION      = DEF_FRICTION
) (
    input  logic [X_W-1:0]          cur_x,
    input  logic [Y_W-1:0]          cur_y,
    input  logic signed [VEL_W-1:0] cur_vx,
    input  logic signed [VEL_W-1:0] cur_vy,
    input  logic                    cur_moving,
    input  logic                    cur_gone,
    input  logic                    hit,
    input  logic signed [VEL_W-1:0] hit_vx,
    input  logic signed [VEL_W-1:0] hit_vy,
    output logic [X_W-1:0]          nxt_x,
    output logic [Y_W-1:0]          nxt_y,
    output logic signed [VEL_W-1:0] nxt_vx,
    output logic signed [VEL_W-1:0] nxt_vy,
    output logic                    nxt_moving,
    output logic                    nxt_gone
);
    localparam int WXY = (X_W > Y_W) ? X_W : Y_W;
    localparam int W   = ((WXY > VEL_W) ? WXY : VEL_W) + 1;
    localparam logic signed [W-1:0] SCR_W = W'(SCREEN_WIDTH);
    localparam logic signed [W-1:0] SCR_H = W'(SCREEN_HEIGHT);

`ifdef PIN_PHYSICS_FRICTION_EN
    localparam logic signed [VEL_W-1:0] FR_POS = VEL_W'(FRICTION);
    localparam logic signed [VEL_W-1:0] FR_NEG = VEL_W'(-FRICTION);

    // Shrinks magnitude toward zero and never crosses it.
    function automatic logic signed [VEL_W-1:0] apply_friction(input logic signed [VEL_W-1:0] v);
        if (v > FR_POS)      return v - FR_POS;
        else if (v < FR_NEG) return v - FR_NEG;
        else                 return '0;
    endfunction
`endif

    logic signed [VEL_W-1:0] vx_use, vy_use;
    logic signed [W-1:0]     sum_x, sum_y;
    logic                    active, out_of_range;

    always_comb begin
        vx_use = hit ? hit_vx : cur_vx;
        vy_use = hit ? hit_vy : cur_vy;
        active = !cur_gone && (hit || cur_moving);
        sum_x  = $signed({{(W-X_W){1'b0}}, cur_x}) + $signed({{(W-VEL_W){vx_use[VEL_W-1]}}, vx_use});
        sum_y  = $signed({{(W-Y_W){1'b0}}, cur_y}) + $signed({{(W-VEL_W){vy_use[VEL_W-1]}}, vy_use});
        out_of_range = sum_x[W-1] || (sum_x >= SCR_W) || sum_y[W-1] || (sum_y >= SCR_H);

        nxt_x      = cur_x;
        nxt_y      = cur_y;
        nxt_vx     = cur_vx;
        nxt_vy     = cur_vy;
        nxt_moving = cur_moving;
        nxt_gone   = cur_gone;

        if (active) begin
            if (out_of_range) begin
                nxt_gone   = 1'b1;
                nxt_moving = 1'b0;
                nxt_vx     = '0;
                nxt_vy     = '0;
            end else begin
                nxt_x = sum_x[X_W-1:0];
                nxt_y = sum_y[Y_W-1:0];
`ifdef PIN_PHYSICS_FRICTION_EN
                nxt_vx     = apply_friction(vx_use);
                nxt_vy     = apply_friction(vy_use);
                nxt_moving = |{nxt_vx, nxt_vy};
`else
                nxt_vx     = vx_use;
                nxt_vy     = vy_use;
                nxt_moving = 1'b1;
`endif
            end
        end
    end
endmodule

// File: rtl/pin_physics.sv
// rtl/pin_physics.sv - bowling pin rack physics, one pin per cycle (PIN_PHYSICS_FRICTION_EN enables friction)
module pin_physics
    import pin_physics_pkg::*;
#(
    parameter int ROWS          = DEF_ROWS,
    parameter int VEL_W         = DEF_VEL_W,
    parameter int X_W           = DEF_X_W,
    parameter int Y_W           = DEF_Y_W,
    parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
    parameter int FRICTION      = DEF_FRICTION,
    parameter int SPACING_X     = DEF_SPACING_X,
    parameter int SPACING_Y     = DEF_SPACING_Y,
    parameter int X0            = 0,
    parameter int Y0            = 0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    pin_physics_if.slave  bus
);
    localparam int NUM_PINS = num_pins(ROWS);
    localparam int IDX_W    = (NUM_PINS > 1) ? $clog2(NUM_PINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PINS - 1);

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx;
    logic [NUM_PINS-1:0]     hit_q;
    logic signed [VEL_W-1:0] hvx_q [NUM_PINS];
    logic signed [VEL_W-1:0] hvy_q [NUM_PINS];

    logic [X_W-1:0]          px  [NUM_PINS];
    logic [Y_W-1:0]          py  [NUM_PINS];
    logic signed [VEL_W-1:0] pvx [NUM_PINS];
    logic signed [VEL_W-1:0] pvy [NUM_PINS];
    logic [NUM_PINS-1:0]     moving, gone;

    logic [X_W-1:0]          nx;
    logic [Y_W-1:0]          ny;
    logic signed [VEL_W-1:0] nvx, nvy;
    logic                    nmoving, ngone;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.valid_in) state_next = UPDATE;
            UPDATE:  if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Reset overrides the state decode so the handshake is clean on the reset cycle itself.
    assign bus.ready_out = rst_in || (state == IDLE);
    assign bus.done_out  = !rst_in && (state == DONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx   <= '0;
            hit_q <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                hvx_q[i] <= '0;
                hvy_q[i] <= '0;
            end
        end else if (state == IDLE && bus.valid_in) begin
            idx   <= '0;
            hit_q <= bus.pins_hit_in;
            for (int i = 0; i < NUM_PINS; i++) begin
                hvx_q[i] <= bus.pins_vx_in[i];
                hvy_q[i] <= bus.pins_vy_in[i];
            end
        end else if (state == UPDATE) begin
            idx <= idx + 1'b1;
        end
    end

    pin_step #(
        .VEL_W         (VEL_W),
        .X_W           (X_W),
        .Y_W           (Y_W),
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .FRICTION      (FRICTION)
    ) u_step (
        .cur_x      (px[idx]),
        .cur_y      (py[idx]),
        .cur_vx     (pvx[idx]),
        .cur_vy     (pvy[idx]),
        .cur_moving (moving[idx]),
        .cur_gone   (gone[idx]),
        .hit        (hit_q[idx]),
        .hit_vx     (hvx_q[idx]),
        .hit_vy     (hvy_q[idx]),
        .nxt_x      (nx),
        .nxt_y      (ny),
        .nxt_vx     (nvx),
        .nxt_vy     (nvy),
        .nxt_moving (nmoving),
        .nxt_gone   (ngone)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            moving <= '0;
            gone   <= '0;
            for (int i = 0; i < NUM_PINS; i++) begin
                px[i]  <= X_W'(rack_x(i, ROWS, X0, SPACING_X));
                py[i]  <= Y_W'(rack_y(i, ROWS, Y0, SPACING_Y));
                pvx[i] <= '0;
                pvy[i] <= '0;
            end
        end else if (state == UPDATE) begin
            px[idx]     <= nx;
            py[idx]     <= ny;
            pvx[idx]    <= nvx;
            pvy[idx]    <= nvy;
            moving[idx] <= nmoving;
            gone[idx]   <= ngone;
        end
    end

    assign bus.pins_x          = px;
    assign bus.pins_y          = py;
    assign bus.pins_vx_out     = pvx;
    assign bus.pins_vy_out     = pvy;
    assign bus.pins_moving_out = moving;
    assign bus.pins_gone_out   = gone;
endmodule
